uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
Buffered byte source sitting directly upstream of the UART transmitter. It accepts bytes from a host-side write port into a circular FIFO and feeds them one at a time to the transmitter's start/din/done handshake. The host can queue bursts without tracking the transmitter's per-bit timing. Shares the transmitter's clock and reset domain.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
DATA_W, 8, byte width; matches transmitter din
AFULL_THRESH, DEPTH-2, almost-full level; used only with UART_TXQ_AFULL_EN

Ports:
clk  in  1  transmitter-domain clock, rising edge
rstn  in  1  asynchronous active-low reset
wr_en  in  1  host write strobe
wr_data  in  DATA_W  host byte
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  bytes stored, excluding the in-flight byte
overflow  out  1  sticky: write attempted while full
ovf_clr  in  1  synchronous clear of overflow
flush  in  1  synchronous discard of all queued bytes
tx_en  in  1  permit launching new bytes
busy  out  1  (state != IDLE) or (count != 0)
tx_start  out  1  one-cycle start pulse to the transmitter
tx_din  out  DATA_W  byte to the transmitter; held stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit

Behaviour:
- Reset (rstn low, async): wr/rd pointers, count, overflow, tx_start, tx_din all 0; state IDLE; empty=1, full=0, busy=0.
- All outputs are registered, or decoded only from registered state.
- Write: on an edge with wr_en=1, full=0, flush=0, store to mem[wr_ptr], wr_ptr++ (wraps at DEPTH), count++.
- wr_en=1 with full=1: byte dropped and overflow set. full uses registered count, so a same-cycle pop does not make room.
- overflow: set has priority over ovf_clr in the same cycle.
- flush=1: wr_ptr=rd_ptr=0, count=0. A write in the same cycle is dropped and does not set overflow. An in-flight byte (WAIT) is not aborted.
- FSM states: IDLE, START, WAIT.
  - IDLE -> START when tx_en=1 and count!=0. On this edge: tx_din <= mem[rd_ptr], rd_ptr++, count--.
  - If a write and a pop share an edge, count is unchanged.
  - START: tx_start=1 for exactly this one cycle. Next state is WAIT unconditionally; tx_done is ignored in START.
  - WAIT: tx_start=0, tx_din held. On tx_done=1 -> IDLE.
  - tx_done in IDLE is ignored.
- Minimum spacing: one IDLE cycle between tx_done and the next tx_start.
- Latency: write accepted at edge k into an empty idle queue with tx_en=1 -> tx_start high in the cycle after edge k+1.
- tx_en deasserted in WAIT: the current byte completes, then the FSM stays in IDLE with data retained.
- Reset mid-transfer: the queue and FSM clear immediately; the transmitter is reset by the same rstn.

Optional Feature:
UART_TXQ_AFULL_EN
- Defined: adds output port almost_full (1 bit), registered, high when count >= AFULL_THRESH (count value after the current edge's update).
- Undefined: port and logic absent; AFULL_THRESH unused.

Test Plan:
- Reset then idle: rstn low mid-cycle -> all outputs 0, empty=1 asynchronously; no tx_start for 100 cycles with tx_en=1.
- Single byte: write 0xA5 at edge k -> tx_start pulse after edge k+1, tx_din=0xA5 held until tx_done; busy drops the cycle after tx_done.
- Burst ordering: write 0x01..0x10 back-to-back (DEPTH=16), tx_done 20 cycles after each start -> bytes launched in order 0x01..0x10. First pop frees a slot, so full never asserts (max count 15). Each next tx_start is 2 cycles after the previous tx_done.
- Overflow: tx_en=0, write 17 bytes -> full=1 after the 16th, 17th dropped, overflow=1. ovf_clr together with another write-while-full -> overflow stays 1. ovf_clr alone -> overflow 0.
- Flush: queue 5 bytes, tx_en=1, flush during WAIT of the first byte -> count=0, first byte completes, no further tx_start. flush with wr_en in the same cycle -> count stays 0, overflow stays 0.
- Wrap and simultaneous events: 40 writes interleaved with pops so pointers wrap twice, including a write on the pop edge -> count unchanged that edge, data order intact. With UART_TXQ_AFULL_EN and AFULL_THRESH=14: almost_full rises at count 14 and falls at 13.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: circular byte FIFO that feeds a UART transmitter through
// its start/din/done handshake, so the host can queue bursts of bytes.
//
// Ports:
//   clk, rstn          transmitter-domain clock, async active-low reset
//   wr_en, wr_data     host write strobe and byte
//   full, empty, count FIFO status (count excludes the in-flight byte)
//   overflow, ovf_clr  sticky write-while-full flag and its clear
//   flush              synchronous discard of all queued bytes
//   tx_en              permit launching new bytes
//   busy               FSM active or bytes queued
//   tx_start, tx_din   start pulse and byte to the transmitter
//   tx_done            end-of-stop-bit pulse from the transmitter
//   almost_full        only when UART_TXQ_AFULL_EN is defined
//
// Optional feature macro: UART_TXQ_AFULL_EN (adds almost_full and the
// AFULL_THRESH parameter).
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int DATA_W = 8
`ifdef UART_TXQ_AFULL_EN
    ,
    parameter int AFULL_THRESH = DEPTH - 2
`endif
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    input  logic                     flush,
    input  logic                     tx_en,
    output logic                     busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_din,
    input  logic                     tx_done
`ifdef UART_TXQ_AFULL_EN
    ,
    output logic                     almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              pop;

    // Status decodes come only from registered state.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE) || (count != '0);
    assign tx_start = (state == START);

    // full is the registered value, so a pop on the same edge never
    // makes room for the write.
    assign push = wr_en && !full && !flush;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                // A flush discards everything queued, including the byte
                // that would otherwise be launched on this edge.
                if (tx_en && (count != '0) && !flush) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tx_din <= '0;
        end else begin
            count <= count_nxt;
            if (pop) begin
                tx_din <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Setting wins over clearing; a write dropped by flush is not an
    // overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !flush) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_TXQ_AFULL_EN
    localparam logic [CW-1:0] AF_CNT = CW'(AFULL_THRESH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_nxt >= AF_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed self-checking bench for uart_tx_queue.
// A small transmitter responder answers tx_start with tx_done.
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       flush = 1'b0;
    logic       tx_en = 1'b0;
    logic       busy;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_done = 1'b0;
`ifdef UART_TXQ_AFULL_EN
    logic       almost_full;
`endif

    uart_tx_queue #(
        .DEPTH (16),
        .DATA_W(8)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .overflow(overflow),
        .ovf_clr (ovf_clr),
        .flush   (flush),
        .tx_en   (tx_en),
        .busy    (busy),
        .tx_start(tx_start),
        .tx_din  (tx_din),
        .tx_done (tx_done)
`ifdef UART_TXQ_AFULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Transmitter responder
    logic       resp_en = 1'b0;
    int         gap = 20;
    logic [7:0] launched[$];
    int         hold_err = 0;
    int         gap_err = 0;
    int         last_done = -100;
    logic       gap_chk = 1'b0;

    initial begin
        logic [7:0] held;
        forever begin
            tick();
            if (resp_en && tx_start) begin
                if (gap_chk && last_done >= 0 && cyc != last_done + 1)
                    gap_err++;
                held = tx_din;
                launched.push_back(held);
                repeat (gap - 1) begin
                    tick();
                    if (tx_din !== held || tx_start !== 1'b0)
                        hold_err++;
                end
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
                last_done = cyc;
            end
        end
    end

    logic mon_en = 1'b0;
    int   maxc = 0;
    logic full_seen = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(count) > maxc) maxc = int'(count);
            if (full) full_seen = 1'b1;
        end
    end

    task automatic wait_drain(input int n, input int budget,
                              input string tag);
        int c;
        c = 0;
        while (!(launched.size() == n && !busy) && c < budget) begin
            tick();
            c++;
        end
        check(tag, c < budget, 1'b1);
    endtask

    initial begin
        int nstart;
        int c;
        int err;

        // Asynchronous reset
        #2 rstn = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_start", tx_start, 0);
        check("rst_din", tx_din, 0);
        check("rst_ovf", overflow, 0);
        #5 rstn = 1'b1;
        tick();

        // Reset in the middle of a transfer
        tx_en = 1'b1;
        wr(8'h3C);
        tick();
        tick();
        check("mid_din", tx_din, 8'h3C);
        check("mid_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_din", tx_din, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_start", tx_start, 0);
        #1 rstn = 1'b1;
        tick();

        nstart = 0;
        repeat (100) begin
            tick();
            if (tx_start) nstart++;
        end
        check("idle_nostart", nstart, 0);

        // Single byte
        wr(8'hA5);
        check("s_count1", count, 1);
        check("s_start0", tx_start, 0);
        tick();
        check("s_start1", tx_start, 1);
        check("s_din", tx_din, 8'hA5);
        check("s_count0", count, 0);
        err = 0;
        repeat (6) begin
            tick();
            if (tx_start !== 1'b0 || tx_din !== 8'hA5) err++;
        end
        check("s_hold", err, 0);
        check("s_busy_wait", busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("s_busy_after", busy, 0);
        tick();
        check("s_no_restart", tx_start, 0);

        // Burst ordering
        launched.delete();
        gap = 20;
        hold_err = 0;
        gap_err = 0;
        last_done = -100;
        gap_chk = 1'b1;
        resp_en = 1'b1;
        maxc = 0;
        full_seen = 1'b0;
        mon_en = 1'b1;
        for (int i = 1; i <= 16; i++) wr(8'(i));
        wait_drain(16, 600, "burst_timeout");
        mon_en = 1'b0;
        gap_chk = 1'b0;
        for (int i = 0; i < 16; i++)
            check($sformatf("burst_%0d", i), launched[i], 32'(i + 1));
        check("burst_maxc", maxc, 15);
        check("burst_full", full_seen, 0);
        check("burst_gap", gap_err, 0);
        check("burst_hold", hold_err, 0);

        // Overflow
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        check("ov_full", full, 1);
        check("ov_count", count, 16);
        check("ov_flag0", overflow, 0);
        wr(8'hEE);
        check("ov_set", overflow, 1);
        check("ov_count17", count, 16);
        wr_en = 1'b1;
        wr_data = 8'hDD;
        ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        check("ov_clr_pri", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ov_clr", overflow, 0);
        launched.delete();
        gap = 3;
        tx_en = 1'b1;
        wait_drain(16, 300, "ov_drain_timeout");
        err = 0;
        for (int i = 0; i < 16; i++)
            if (launched[i] !== 8'(8'h20 + i)) err++;
        check("ov_order", err, 0);

        // Flush during WAIT
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'(8'h51 + i));
        launched.delete();
        gap = 10;
        tx_en = 1'b1;
        c = 0;
        while (launched.size() == 0 && c < 20) begin
            tick();
            c++;
        end
        check("fl_start_seen", c < 20, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_count", count, 0);
        check("fl_busy", busy, 1);
        wait_drain(1, 50, "fl_drain_timeout");
        repeat (30) tick();
        check("fl_launched", launched.size(), 1);
        check("fl_first", launched[0], 8'h51);

        // Flush with a write while full
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(8'h60 + i));
        wr_en = 1'b1;
        wr_data = 8'h77;
        flush = 1'b1;
        tick();
        wr_en = 1'b0;
        flush = 1'b0;
        check("fw_count", count, 0);
        check("fw_ovf", overflow, 0);
        check("fw_empty", empty, 1);

        // Write on the pop edge, then wrap the pointers twice
        gap = 3;
        wr(8'h80);
        wr(8'h81);
        launched.delete();
        wr_en = 1'b1;
        wr_data = 8'h82;
        tx_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("wp_count", count, 2);
        check("wp_start", tx_start, 1);
        check("wp_din", tx_din, 8'h80);
        for (int i = 3; i < 40; i++) begin
            c = 0;
            while (full && c < 100) begin
                tick();
                c++;
            end
            wr(8'(8'h80 + i));
        end
        wait_drain(40, 2000, "wrap_timeout");
        err = 0;
        for (int i = 0; i < 40; i++)
            if (launched[i] !== 8'(8'h80 + i)) err++;
        check("wrap_order", err, 0);

`ifdef UART_TXQ_AFULL_EN
        tx_en = 1'b0;
        for (int i = 0; i < 13; i++) wr(8'(i));
        check("af_13", almost_full, 0);
        wr(8'h0D);
        check("af_14", almost_full, 1);
        tx_en = 1'b1;
        tick();
        tx_en = 1'b0;
        check("af_pop13", almost_full, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (30) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
